multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//  Multi-cycle control FSM for the MIPS-style datapath: sequences fetch, decode/register read, execute,
//  memory and register-file write-back. Drives the enables and mux selects of the DECODE stage
//  (RF_WrEn, RF_WrData_sel, RF_B_sel) plus the PC, IR, ALU and data-memory controls.
//  Sits beside the datapath top; consumes the latched instruction and the ALU zero flag.
// PARAMETERS
//  ALU_FUNC_W   4   width of ALU_func (codes: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 not)
//  TRAP_OPC     6'b111110   opcode reserved for halt; FSM parks in HALT
// PORTS
//  Clk            in   1   single system clock, rising edge
//  Reset          in   1   synchronous, active-high
//  Instr          in   32  instruction from IR; stable from DECODE until next IFETCH
//  ALU_zero       in   1   ALU zero flag, valid in EXEC
//  Mem_Ready      in   1   data-memory done (used only with CTRL_MEM_WAIT_EN)
//  PC_LdEn        out  1   PC register load
//  PC_sel         out  1   0: PC+4, 1: PC+4+(Immed<<2)
//  IR_LdEn        out  1   IR load
//  RF_WrEn        out  1   register-file write enable
//  RF_WrData_sel  out  1   0: ALU_out, 1: MEM_out
//  RF_B_sel       out  1   0: rt=Instr[15:11], 1: rd=Instr[20:16]
//  ALU_Bin_sel    out  1   0: RF_B, 1: Immed
//  ALU_func       out  4   ALU operation
//  Mem_WrEn       out  1   data-memory write
//  Halted         out  1   FSM in HALT
//  Illegal        out  1   one-cycle pulse in DECODE on unknown opcode
// BEHAVIOUR
//  - States: IFETCH -> DECODE -> {EXEC_R, EXEC_I, EXEC_MEM, EXEC_BR, HALT}.
//    EXEC_R/EXEC_I -> WB_ALU -> IFETCH; EXEC_MEM -> MEM -> (lw: WB_MEM | sw: IFETCH) ; EXEC_BR -> IFETCH.
//  - Opcodes: 100000 R-type (ALU_func=Instr[3:0]); 110000 addi; 110010 andi; 110011 ori;
//    001111 lw; 011111 sw; 000000 beq; 000001 bne; 111111 b; TRAP_OPC halt; others illegal.
//  - Outputs decoded from state register + opcode (Moore-style); exactly one cycle per state.
//  - IFETCH: IR_LdEn=1. DECODE: all enables 0; RF_B_sel=1 for sw/beq/bne, else 0.
//  - EXEC_I/EXEC_MEM: ALU_Bin_sel=1, ALU_func add/and/or per opcode. EXEC_BR: ALU_func=sub,
//    ALU_Bin_sel=0; PC_LdEn=1, PC_sel=1 if (beq&ALU_zero)|(bne&!ALU_zero)|b, else PC_sel=0.
//  - PC_LdEn=1,PC_sel=0 in WB_ALU, WB_MEM, MEM(sw) and EXEC_BR not-taken: each instruction loads PC once.
//  - WB_ALU: RF_WrEn=1, RF_WrData_sel=0. WB_MEM: RF_WrEn=1, RF_WrData_sel=1. MEM(sw): Mem_WrEn=1.
//  - Latency: R/I 4 cycles, lw 5, sw 4, branch 3 (CPI per instruction class).
//  - Illegal opcode: Illegal pulses in DECODE, PC_LdEn=1 PC_sel=0 next cycle (skip), back to IFETCH.
//  - HALT: all enables 0, Halted=1, stays until Reset.
//  - Reset: state<=IFETCH on the clock edge where Reset=1; while Reset=1 all enable outputs forced 0
//    regardless of state (mid-instruction reset never writes RF/memory). Halted, Illegal reset to 0.
// CONFIGURATION
//  CTRL_MEM_WAIT_EN defined: MEM state holds (Mem_WrEn held for sw) until Mem_Ready=1; exit in the
//    cycle Mem_Ready is sampled high; PC_LdEn asserted only in that exit cycle.
//  Not defined: Mem_Ready ignored; MEM is exactly one cycle.
// STRUCTURE
//  ctrl_pkg: state encoding localparams, opcode constants, ALU_func codes.
//  Sub-module ctrl_opcode_decode: combinational opcode -> instruction class (R, I, LD, ST, BR, HALT, ILL).
// TESTING
//  - addi r2,r1,5 (0xC0220005) after reset -> RF_WrEn=1,RF_WrData_sel=0 only in cycle 4; PC_LdEn once.
//  - lw (opcode 001111) -> RF_WrEn=1 with RF_WrData_sel=1 in cycle 5; Mem_WrEn never 1.
//  - beq with ALU_zero=1 then 0 -> cycle 3 PC_sel=1 then PC_sel=0; RF_WrEn stays 0.
//  - Reset asserted during MEM of sw -> Mem_WrEn=0 that cycle, next state IFETCH.
//  - Opcode 101010 -> Illegal pulse in DECODE, no RF/mem write; opcode 111110 -> Halted=1 held 20 cycles.
//  - With CTRL_MEM_WAIT_EN, Mem_Ready low 3 cycles on sw -> Mem_WrEn held 4 cycles, PC_LdEn once.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle control FSM: opcodes, ALU function codes,
// instruction classes and FSM states.
package ctrl_pkg;

    localparam int unsigned ALU_FUNC_W = 4;

    localparam logic [5:0] TRAP_OPC_DEFAULT = 6'b111110;

    // Opcodes (Instr[31:26])
    localparam logic [5:0] OPC_RTYPE = 6'b100000;
    localparam logic [5:0] OPC_ADDI  = 6'b110000;
    localparam logic [5:0] OPC_ANDI  = 6'b110010;
    localparam logic [5:0] OPC_ORI   = 6'b110011;
    localparam logic [5:0] OPC_LW    = 6'b001111;
    localparam logic [5:0] OPC_SW    = 6'b011111;
    localparam logic [5:0] OPC_BEQ   = 6'b000000;
    localparam logic [5:0] OPC_BNE   = 6'b000001;
    localparam logic [5:0] OPC_B     = 6'b111111;

    // ALU function codes
    localparam logic [ALU_FUNC_W-1:0] ALU_ADD = 4'b0000;
    localparam logic [ALU_FUNC_W-1:0] ALU_SUB = 4'b0001;
    localparam logic [ALU_FUNC_W-1:0] ALU_AND = 4'b0010;
    localparam logic [ALU_FUNC_W-1:0] ALU_OR  = 4'b0011;
    localparam logic [ALU_FUNC_W-1:0] ALU_NOT = 4'b0100;

    typedef enum logic [2:0] {
        ClsR    = 3'd0,
        ClsI    = 3'd1,
        ClsLd   = 3'd2,
        ClsSt   = 3'd3,
        ClsBr   = 3'd4,
        ClsHalt = 3'd5,
        ClsIll  = 3'd6
    } instr_class_e;

    typedef enum logic [3:0] {
        StIfetch  = 4'd0,
        StDecode  = 4'd1,
        StExecR   = 4'd2,
        StExecI   = 4'd3,
        StExecMem = 4'd4,
        StExecBr  = 4'd5,
        StMem     = 4'd6,
        StWbAlu   = 4'd7,
        StWbMem   = 4'd8,
        StSkip    = 4'd9,
        StHalt    = 4'd10
    } state_e;

endpackage

// File: rtl/ctrl_opcode_decode.sv
// Combinational opcode classifier: maps Instr[31:26] to an instruction class.
module ctrl_opcode_decode
    import ctrl_pkg::*;
#(
    parameter logic [5:0] TRAP_OPC = TRAP_OPC_DEFAULT
) (
    input  logic [5:0] opcode,
    output logic [2:0] instr_class
);

    // Trap opcode takes priority so an overridden TRAP_OPC always halts
    always_comb begin
        instr_class = ClsIll;
        if (opcode == TRAP_OPC) begin
            instr_class = ClsHalt;
        end else begin
            case (opcode)
                OPC_RTYPE:                   instr_class = ClsR;
                OPC_ADDI, OPC_ANDI, OPC_ORI: instr_class = ClsI;
                OPC_LW:                      instr_class = ClsLd;
                OPC_SW:                      instr_class = ClsSt;
                OPC_BEQ, OPC_BNE, OPC_B:     instr_class = ClsBr;
                default:                     instr_class = ClsIll;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for the MIPS-style datapath.
// Optional feature: define CTRL_MEM_WAIT_EN to stall the MEM state until Mem_Ready.
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter logic [5:0] TRAP_OPC = TRAP_OPC_DEFAULT
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [31:0]           Instr,
    input  logic                  ALU_zero,
    input  logic                  Mem_Ready,
    output logic                  PC_LdEn,
    output logic                  PC_sel,
    output logic                  IR_LdEn,
    output logic                  RF_WrEn,
    output logic                  RF_WrData_sel,
    output logic                  RF_B_sel,
    output logic                  ALU_Bin_sel,
    output logic [ALU_FUNC_W-1:0] ALU_func,
    output logic                  Mem_WrEn,
    output logic                  Halted,
    output logic                  Illegal
);

    state_e     state;
    logic [5:0] opcode;
    logic [2:0] instr_class;
    logic       branch_taken;
    logic       mem_done;
    logic       unused_instr;

    assign opcode       = Instr[31:26];
    assign unused_instr = ^Instr[25:ALU_FUNC_W];

    ctrl_opcode_decode #(
        .TRAP_OPC (TRAP_OPC)
    ) u_decode (
        .opcode      (opcode),
        .instr_class (instr_class)
    );

`ifdef CTRL_MEM_WAIT_EN
    assign mem_done = Mem_Ready;
`else
    logic unused_mem_ready;
    assign mem_done         = 1'b1;
    assign unused_mem_ready = Mem_Ready;
`endif

    assign branch_taken = ((opcode == OPC_BEQ) &&  ALU_zero) ||
                          ((opcode == OPC_BNE) && !ALU_zero) ||
                           (opcode == OPC_B);

    // State sequencing; every state lasts one cycle except MEM (wait) and HALT
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= StIfetch;
        end else begin
            case (state)
                StIfetch: state <= StDecode;
                StDecode: begin
                    case (instr_class)
                        ClsR:         state <= StExecR;
                        ClsI:         state <= StExecI;
                        ClsLd, ClsSt: state <= StExecMem;
                        ClsBr:        state <= StExecBr;
                        ClsHalt:      state <= StHalt;
                        default:      state <= StSkip;
                    endcase
                end
                StExecR, StExecI: state <= StWbAlu;
                StExecMem:        state <= StMem;
                StMem: begin
                    if (mem_done) begin
                        state <= (instr_class == ClsLd) ? StWbMem : StIfetch;
                    end
                end
                StHalt:  state <= StHalt;
                default: state <= StIfetch;
            endcase
        end
    end

    // Output decode from state and opcode; Reset masks every enable
    always_comb begin
        PC_LdEn       = 1'b0;
        PC_sel        = 1'b0;
        IR_LdEn       = 1'b0;
        RF_WrEn       = 1'b0;
        RF_WrData_sel = 1'b0;
        RF_B_sel      = 1'b0;
        ALU_Bin_sel   = 1'b0;
        ALU_func      = ALU_ADD;
        Mem_WrEn      = 1'b0;
        Halted        = 1'b0;
        Illegal       = 1'b0;
        case (state)
            StIfetch: IR_LdEn = 1'b1;
            StDecode: begin
                // sw and compares need rd on the second read port
                RF_B_sel = (opcode == OPC_SW) || (opcode == OPC_BEQ) || (opcode == OPC_BNE);
                Illegal  = (instr_class == ClsIll);
            end
            StExecR: ALU_func = Instr[ALU_FUNC_W-1:0];
            StExecI: begin
                ALU_Bin_sel = 1'b1;
                case (opcode)
                    OPC_ANDI: ALU_func = ALU_AND;
                    OPC_ORI:  ALU_func = ALU_OR;
                    default:  ALU_func = ALU_ADD;
                endcase
            end
            StExecMem: ALU_Bin_sel = 1'b1;
            StExecBr: begin
                ALU_func = ALU_SUB;
                PC_LdEn  = 1'b1;
                PC_sel   = branch_taken;
            end
            StMem: begin
                if (instr_class == ClsSt) begin
                    Mem_WrEn = 1'b1;
                    PC_LdEn  = mem_done;
                end
            end
            StWbAlu: begin
                RF_WrEn = 1'b1;
                PC_LdEn = 1'b1;
            end
            StWbMem: begin
                RF_WrEn       = 1'b1;
                RF_WrData_sel = 1'b1;
                PC_LdEn       = 1'b1;
            end
            StSkip:  PC_LdEn = 1'b1;
            StHalt:  Halted  = 1'b1;
            default: ;
        endcase
        if (Reset) begin
            PC_LdEn  = 1'b0;
            IR_LdEn  = 1'b0;
            RF_WrEn  = 1'b0;
            Mem_WrEn = 1'b0;
            Halted   = 1'b0;
            Illegal  = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle expected control words are queued
// per instruction and compared against the DUT each cycle on the falling edge.
module tb_multicycle_control;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [31:0] Instr = 32'd0;
    logic        ALU_zero = 1'b0;
    logic        Mem_Ready = 1'b0;
    logic        PC_LdEn, PC_sel, IR_LdEn, RF_WrEn, RF_WrData_sel, RF_B_sel, ALU_Bin_sel;
    logic [3:0]  ALU_func;
    logic        Mem_WrEn, Halted, Illegal;

    always #5 Clk = ~Clk;

    multicycle_control dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .Instr         (Instr),
        .ALU_zero      (ALU_zero),
        .Mem_Ready     (Mem_Ready),
        .PC_LdEn       (PC_LdEn),
        .PC_sel        (PC_sel),
        .IR_LdEn       (IR_LdEn),
        .RF_WrEn       (RF_WrEn),
        .RF_WrData_sel (RF_WrData_sel),
        .RF_B_sel      (RF_B_sel),
        .ALU_Bin_sel   (ALU_Bin_sel),
        .ALU_func      (ALU_func),
        .Mem_WrEn      (Mem_WrEn),
        .Halted        (Halted),
        .Illegal       (Illegal)
    );

    // Control word layout: {PC_LdEn, PC_sel, IR_LdEn, RF_WrEn, RF_WrData_sel, RF_B_sel,
    //                       ALU_Bin_sel, ALU_func[3:0], Mem_WrEn, Halted, Illegal}
    localparam logic [13:0] Z     = 14'h0000;
    localparam logic [13:0] B_PCL = 14'h2000;
    localparam logic [13:0] B_PCS = 14'h1000;
    localparam logic [13:0] B_IR  = 14'h0800;
    localparam logic [13:0] B_RFW = 14'h0400;
    localparam logic [13:0] B_WDS = 14'h0200;
    localparam logic [13:0] B_BS  = 14'h0100;
    localparam logic [13:0] B_BIN = 14'h0080;
    localparam logic [13:0] F_ALU = 14'h0078;
    localparam logic [13:0] B_MW  = 14'h0004;
    localparam logic [13:0] B_H   = 14'h0002;
    localparam logic [13:0] B_ILL = 14'h0001;
    localparam logic [13:0] EN    = B_PCL | B_IR | B_RFW | B_MW | B_H | B_ILL;
    localparam logic [13:0] M_EX  = EN | B_BIN | F_ALU;
    localparam logic [13:0] M_WB  = EN | B_WDS | B_PCS;

`ifdef CTRL_MEM_WAIT_EN
    localparam logic RDY_EXIT = 1'b1;
    localparam int   SW_WAIT  = 3;
    localparam int   LW_WAIT  = 2;
`else
    localparam logic RDY_EXIT = 1'b0;
    localparam int   SW_WAIT  = 0;
    localparam int   LW_WAIT  = 0;
`endif

    typedef struct {
        string       tag;
        logic [31:0] ins;
        logic        zero;
        logic        rst;
        logic        rdy;
        logic [13:0] val;
        logic [13:0] mask;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail = 0;
    string       cur_name;
    logic [31:0] cur_ins;
    logic        cur_zero;
    int          cur_cyc;
    int          cur_rst_at;
    bit          cur_done;

    function automatic logic [13:0] fn(input logic [3:0] f);
        return {7'd0, f, 3'd0};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
        end
    endtask

    // Queue one expected cycle; the cycle chosen for reset replaces the rest of the instruction
    task automatic add(input logic rdy, input logic [13:0] val, input logic [13:0] mask);
        exp_t e;
        if (cur_done) return;
        e.tag  = $sformatf("%s.c%0d", cur_name, cur_cyc);
        e.ins  = cur_ins;
        e.zero = cur_zero;
        e.rdy  = rdy;
        if (cur_cyc == cur_rst_at) begin
            e.rst    = 1'b1;
            e.val    = Z;
            e.mask   = EN;
            cur_done = 1'b1;
        end else begin
            e.rst  = 1'b0;
            e.val  = val;
            e.mask = mask;
        end
        sb.push_back(e);
        cur_cyc++;
    endtask

    task automatic push_reset(input string name, input int n);
        cur_name = name; cur_ins = 32'd0; cur_zero = 1'b0;
        cur_cyc = 1; cur_rst_at = 1; cur_done = 1'b0;
        for (int k = 0; k < n; k++) begin
            cur_done = 1'b0; cur_rst_at = cur_cyc;
            add(1'b0, Z, EN);
        end
    endtask

    task automatic push_instr(input string name, input logic [31:0] ins, input logic zero,
                              input int waits, input int rst_at);
        logic [5:0] op;
        logic       is_r, is_i, is_lw, is_sw, is_br, is_halt, is_ill, taken;
        logic [3:0] ifn;
        op      = ins[31:26];
        is_r    = (op == 6'b100000);
        is_i    = (op == 6'b110000) || (op == 6'b110010) || (op == 6'b110011);
        is_lw   = (op == 6'b001111);
        is_sw   = (op == 6'b011111);
        is_br   = (op == 6'b000000) || (op == 6'b000001) || (op == 6'b111111);
        is_halt = (op == 6'b111110);
        is_ill  = !(is_r || is_i || is_lw || is_sw || is_br || is_halt);
        taken   = ((op == 6'b000000) && zero) || ((op == 6'b000001) && !zero) ||
                  (op == 6'b111111);
        ifn     = (op == 6'b110010) ? 4'b0010 : (op == 6'b110011) ? 4'b0011 : 4'b0000;
        cur_name = name; cur_ins = ins; cur_zero = zero;
        cur_cyc = 1; cur_rst_at = rst_at; cur_done = 1'b0;

        add(1'b0, B_IR, EN);
        add(1'b0, ((is_sw || op == 6'b000000 || op == 6'b000001) ? B_BS : Z) |
                  (is_ill ? B_ILL : Z), EN | B_BS);
        if (is_r) begin
            add(1'b0, fn(ins[3:0]), M_EX);
            add(1'b0, B_RFW | B_PCL, M_WB);
        end else if (is_i) begin
            add(1'b0, B_BIN | fn(ifn), M_EX);
            add(1'b0, B_RFW | B_PCL, M_WB);
        end else if (is_lw || is_sw) begin
            add(1'b0, B_BIN | fn(4'b0000), M_EX);
            for (int k = 0; k < waits; k++) add(1'b0, is_sw ? B_MW : Z, EN);
            add(RDY_EXIT, is_sw ? (B_MW | B_PCL) : Z, EN | (is_sw ? B_PCS : Z));
            if (is_lw) add(1'b0, B_RFW | B_WDS | B_PCL, M_WB);
        end else if (is_br) begin
            add(1'b0, B_PCL | (taken ? B_PCS : Z) | fn(4'b0001), M_EX | B_PCS);
        end else if (is_halt) begin
            for (int k = 0; k < 20; k++) add(1'b0, B_H, EN);
        end else begin
            add(1'b0, B_PCL, EN | B_PCS);
        end
    endtask

    // Drive each queued cycle just after the rising edge, compare on the falling edge
    task automatic run_queue();
        exp_t        e;
        logic [13:0] obs;
        while (sb.size() > 0) begin
            @(posedge Clk);
            #1;
            Instr     = sb[0].ins;
            ALU_zero  = sb[0].zero;
            Reset     = sb[0].rst;
            Mem_Ready = sb[0].rdy;
            @(negedge Clk);
            obs = {PC_LdEn, PC_sel, IR_LdEn, RF_WrEn, RF_WrData_sel, RF_B_sel, ALU_Bin_sel,
                   ALU_func, Mem_WrEn, Halted, Illegal};
            e = sb.pop_front();
            check_eq(e.tag, {18'd0, obs & e.mask}, {18'd0, e.val & e.mask});
        end
    endtask

    initial begin
        push_reset("reset", 3);
        push_instr("addi",  32'hC022_0005, 1'b0, 0, 0);
        push_instr("r_sub", 32'h8022_1801, 1'b0, 0, 0);
        push_instr("r_not", 32'h8022_1804, 1'b1, 0, 0);
        push_instr("andi",  32'hC822_00FF, 1'b0, 0, 0);
        push_instr("ori",   32'hCC22_0F00, 1'b0, 0, 0);
        push_instr("lw",    32'h3C22_0010, 1'b0, LW_WAIT, 0);
        push_instr("sw",    32'h7C22_0010, 1'b0, SW_WAIT, 0);
        push_instr("beq_t", 32'h0022_0003, 1'b1, 0, 0);
        push_instr("beq_n", 32'h0022_0003, 1'b0, 0, 0);
        push_instr("bne_t", 32'h0422_0003, 1'b0, 0, 0);
        push_instr("bne_n", 32'h0422_0003, 1'b1, 0, 0);
        push_instr("b",     32'hFC00_0007, 1'b1, 0, 0);
        push_instr("sw_rst", 32'h7C22_0010, 1'b0, SW_WAIT, 4);
        push_instr("r_rst", 32'h8022_1800, 1'b0, 0, 3);
        push_instr("ill",   32'hA800_0000, 1'b0, 0, 0);
        push_instr("addi2", 32'hC022_0001, 1'b0, 0, 0);
        push_instr("halt",  32'hF800_0000, 1'b0, 0, 0);
        push_reset("halt_rst", 2);
        push_instr("addi3", 32'hC022_0002, 1'b0, 0, 0);
        run_queue();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
